// File: rtl/pu_alu_issue.sv
// Decode/issue stage for the PU ALU: decodes RV32I OP/OP-IMM words, reads the
// register file with writeback bypass, tracks busy registers, registers the bundle.
module pu_alu_issue #(
    parameter int unsigned IMM_WIDTH = 32,
    parameter int unsigned RF_WIDTH  = 32,
    parameter int unsigned NUM_REGS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_use_imm,
    output logic [IMM_WIDTH-1:0] out_imm,
    output logic [RF_WIDTH-1:0]  out_rs1,
    output logic [RF_WIDTH-1:0]  out_rs2,
    output logic [2:0]           out_funct3,
    output logic [4:0]           out_funct5,
    output logic [4:0]           out_rd,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd,
    input  logic [RF_WIDTH-1:0]  wb_data,
    output logic                 illegal
);

    localparam int unsigned REG_IDX_W = $clog2(NUM_REGS);
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  F7_BASE    = 7'b0000000;
    localparam logic [6:0]  F7_ALT     = 7'b0100000;
    localparam logic [2:0]  F3_ADD_SUB = 3'b000;
    localparam logic [2:0]  F3_SLL     = 3'b001;
    localparam logic [2:0]  F3_SR      = 3'b101;

    logic                 out_valid_q, out_valid_d;
    logic                 use_imm_q, use_imm_d;
    logic [IMM_WIDTH-1:0] imm_q, imm_d;
    logic [RF_WIDTH-1:0]  rs1_val_q, rs1_val_d;
    logic [RF_WIDTH-1:0]  rs2_val_q, rs2_val_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [4:0]           funct5_q, funct5_d;
    logic [4:0]           rd_q, rd_d;
    logic                 illegal_q, illegal_d;
    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic [RF_WIDTH-1:0]  rf_q [NUM_REGS];
    logic [RF_WIDTH-1:0]  rf_d [NUM_REGS];

    logic [6:0]           opcode;
    logic [6:0]           funct7;
    logic [2:0]           funct3;
    logic [4:0]           rs1_idx, rs2_idx, rd_idx;
    logic                 dec_legal, dec_use_imm;
    logic [IMM_WIDTH-1:0] dec_imm;
    logic [4:0]           dec_funct5;
    logic                 rs1_busy, rs2_busy, rd_busy, hazard;
    logic                 accept, accept_legal;
    logic [RF_WIDTH-1:0]  rs1_read, rs2_read;

    assign opcode  = in_inst[6:0];
    assign rd_idx  = in_inst[11:7];
    assign funct3  = in_inst[14:12];
    assign rs1_idx = in_inst[19:15];
    assign rs2_idx = in_inst[24:20];
    assign funct7  = in_inst[31:25];

    // Instruction decode and legality
    always_comb begin
        dec_legal   = 1'b0;
        dec_use_imm = 1'b0;
        dec_imm     = '0;
        dec_funct5  = 5'd0;
        case (opcode)
            OPC_OP_IMM: begin
                dec_use_imm = 1'b1;
                case (funct3)
                    F3_SLL: begin
                        dec_legal  = (funct7 == F7_BASE);
                        dec_imm    = IMM_WIDTH'(in_inst[24:20]);
                        dec_funct5 = in_inst[31:27];
                    end
                    F3_SR: begin
                        dec_legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        dec_imm    = IMM_WIDTH'(in_inst[24:20]);
                        dec_funct5 = in_inst[31:27];
                    end
                    default: begin
                        dec_legal = 1'b1;
                        dec_imm   = {{(IMM_WIDTH-12){in_inst[31]}}, in_inst[31:20]};
                    end
                endcase
            end
            OPC_OP: begin
                dec_legal  = (funct7 == F7_BASE) ||
                             ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR)));
                dec_funct5 = in_inst[31:27];
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // A pending writeback to a busy register releases it in the same cycle
    always_comb begin
        rs1_busy = (rs1_idx != 5'd0) && busy_q[REG_IDX_W'(rs1_idx)] && !(wb_valid && (wb_rd == rs1_idx));
        rs2_busy = (rs2_idx != 5'd0) && busy_q[REG_IDX_W'(rs2_idx)] && !(wb_valid && (wb_rd == rs2_idx));
        rd_busy  = (rd_idx  != 5'd0) && busy_q[REG_IDX_W'(rd_idx)]  && !(wb_valid && (wb_rd == rd_idx));
        hazard   = in_valid && dec_legal && (rs1_busy || (!dec_use_imm && rs2_busy) || rd_busy);
    end

    assign in_ready     = (!out_valid_q || out_ready) && !hazard;
    assign accept       = in_valid && in_ready;
    assign accept_legal = accept && dec_legal;

    // Operand read with writeback bypass; x0 always reads zero
    always_comb begin
        rs1_read = '0;
        rs2_read = '0;
        if (rs1_idx != 5'd0) begin
            rs1_read = (wb_valid && (wb_rd == rs1_idx)) ? wb_data : rf_q[REG_IDX_W'(rs1_idx)];
        end
        if (!dec_use_imm && (rs2_idx != 5'd0)) begin
            rs2_read = (wb_valid && (wb_rd == rs2_idx)) ? wb_data : rf_q[REG_IDX_W'(rs2_idx)];
        end
    end

    // Output bundle, scoreboard and register file next state
    always_comb begin
        out_valid_d = out_valid_q;
        use_imm_d   = use_imm_q;
        imm_d       = imm_q;
        rs1_val_d   = rs1_val_q;
        rs2_val_d   = rs2_val_q;
        funct3_d    = funct3_q;
        funct5_d    = funct5_q;
        rd_d        = rd_q;
        illegal_d   = accept && !dec_legal;
        busy_d      = busy_q;
        rf_d        = rf_q;

        if (accept_legal) begin
            out_valid_d = 1'b1;
            use_imm_d   = dec_use_imm;
            imm_d       = dec_imm;
            rs1_val_d   = rs1_read;
            rs2_val_d   = rs2_read;
            funct3_d    = funct3;
            funct5_d    = dec_funct5;
            rd_d        = rd_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (wb_valid) begin
            busy_d[REG_IDX_W'(wb_rd)] = 1'b0;
            if (wb_rd != 5'd0) begin
                rf_d[REG_IDX_W'(wb_rd)] = wb_data;
            end
        end
        // Issue after clear so a same-cycle set on the same register wins
        if (accept_legal && (rd_idx != 5'd0)) begin
            busy_d[REG_IDX_W'(rd_idx)] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            use_imm_q   <= 1'b0;
            imm_q       <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            funct3_q    <= 3'd0;
            funct5_q    <= 5'd0;
            rd_q        <= 5'd0;
            illegal_q   <= 1'b0;
            busy_q      <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            use_imm_q   <= use_imm_d;
            imm_q       <= imm_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            funct3_q    <= funct3_d;
            funct5_q    <= funct5_d;
            rd_q        <= rd_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
            rf_q        <= rf_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_use_imm = use_imm_q;
    assign out_imm     = imm_q;
    assign out_rs1     = rs1_val_q;
    assign out_rs2     = rs2_val_q;
    assign out_funct3  = funct3_q;
    assign out_funct5  = funct5_q;
    assign out_rd      = rd_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_pu_alu_issue.sv
// Bench for pu_alu_issue: directed instruction stream, reference model of the
// issue rules compared every cycle, plus literal checks at key points.
module tb_pu_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic        out_use_imm;
    logic [31:0] out_imm;
    logic [31:0] out_rs1;
    logic [31:0] out_rs2;
    logic [2:0]  out_funct3;
    logic [4:0]  out_funct5;
    logic [4:0]  out_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pu_alu_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_use_imm(out_use_imm), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct5(out_funct5), .out_rd(out_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal(illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] m_rf [32];
    logic        m_busy [32];
    logic        m_valid, m_illegal, m_use_imm;
    logic [31:0] m_imm, m_rs1, m_rs2;
    logic [2:0]  m_f3;
    logic [4:0]  m_f5, m_rd;
    bit          m_live = 1'b0;

    function automatic void decode(input logic [31:0] w, output bit legal, output bit use_imm,
                                   output logic [31:0] imm, output logic [4:0] f5);
        logic [6:0] f7;
        f7 = w[31:25];
        legal = 1'b0; use_imm = 1'b0; imm = 32'd0; f5 = 5'd0;
        if (w[6:0] == 7'h13) begin
            use_imm = 1'b1;
            if (w[14:12] == 3'd1) begin
                legal = (f7 == 7'h00);
                imm = {27'd0, w[24:20]};
                f5 = w[31:27];
            end else if (w[14:12] == 3'd5) begin
                legal = (f7 == 7'h00) || (f7 == 7'h20);
                imm = {27'd0, w[24:20]};
                f5 = w[31:27];
            end else begin
                legal = 1'b1;
                imm = {{20{w[31]}}, w[31:20]};
            end
        end else if (w[6:0] == 7'h33) begin
            legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((w[14:12] == 3'd0) || (w[14:12] == 3'd5)));
            f5 = w[31:27];
        end
    endfunction

    function automatic bit m_busy_eff(input logic [4:0] r);
        return (r != 5'd0) && m_busy[r] && !(wb_valid && (wb_rd == r));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_valid && (wb_rd == r)) return wb_data;
        return m_rf[r];
    endfunction

    function automatic bit m_ready();
        bit legal, ui, hz;
        logic [31:0] imm;
        logic [4:0] f5;
        decode(in_inst, legal, ui, imm, f5);
        hz = in_valid && legal && (m_busy_eff(in_inst[19:15]) ||
             (!ui && m_busy_eff(in_inst[24:20])) || m_busy_eff(in_inst[11:7]));
        return (!m_valid || out_ready) && !hz;
    endfunction

    // Model advances on each rising edge using the inputs held across it
    always @(posedge clk) begin
        bit legal, ui, acc;
        logic [31:0] imm;
        logic [4:0] f5;
        if (rst) begin
            m_live = 1'b1;
            m_valid = 1'b0; m_illegal = 1'b0; m_use_imm = 1'b0;
            m_imm = 32'd0; m_rs1 = 32'd0; m_rs2 = 32'd0;
            m_f3 = 3'd0; m_f5 = 5'd0; m_rd = 5'd0;
            for (int i = 0; i < 32; i++) begin
                m_rf[i] = 32'd0;
                m_busy[i] = 1'b0;
            end
        end else if (m_live) begin
            decode(in_inst, legal, ui, imm, f5);
            acc = in_valid && m_ready();
            m_illegal = acc && !legal;
            if (acc && legal) begin
                m_valid = 1'b1;
                m_use_imm = ui;
                m_imm = imm;
                m_rs1 = m_read(in_inst[19:15]);
                m_rs2 = ui ? 32'd0 : m_read(in_inst[24:20]);
                m_f3 = in_inst[14:12];
                m_f5 = f5;
                m_rd = in_inst[11:7];
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_valid) begin
                m_busy[wb_rd] = 1'b0;
                if (wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
            end
            if (acc && legal && (in_inst[11:7] != 5'd0)) m_busy[in_inst[11:7]] = 1'b1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_live) begin
            chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
            chk("cmp_illegal", 32'(illegal), 32'(m_illegal));
            chk("cmp_in_ready", 32'(in_ready), 32'(m_ready()));
            if (m_valid) begin
                chk("cmp_use_imm", 32'(out_use_imm), 32'(m_use_imm));
                chk("cmp_imm", out_imm, m_imm);
                chk("cmp_rs1", out_rs1, m_rs1);
                chk("cmp_rs2", out_rs2, m_rs2);
                chk("cmp_funct3", 32'(out_funct3), 32'(m_f3));
                chk("cmp_funct5", 32'(out_funct5), 32'(m_f5));
                chk("cmp_rd", 32'(out_rd), 32'(m_rd));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = 32'd0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        step(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_out_rs1", out_rs1, 32'd0);
        rst = 1'b0;

        // x1 = 5, then ADDI x2,x1,-3
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        step();
        wb_valid = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFFD08113;
        #1 chk("addi_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_rs1", out_rs1, 32'd5);
        chk("addi_imm", out_imm, 32'hFFFFFFFD);
        chk("addi_use_imm", 32'(out_use_imm), 32'd1);
        chk("addi_funct3", 32'(out_funct3), 32'd0);
        chk("addi_funct5", 32'(out_funct5), 32'd0);
        chk("addi_rd", 32'(out_rd), 32'd2);
        chk("model_addi_imm", m_imm, 32'hFFFFFFFD);
        chk("model_addi_rs1", m_rs1, 32'd5);

        // SRAI x3,x1,4
        in_valid = 1'b1; in_inst = 32'h4040D193;
        step();
        in_valid = 1'b0;
        chk("srai_imm", out_imm, 32'd4);
        chk("srai_funct3", 32'(out_funct3), 32'd5);
        chk("srai_funct5", 32'(out_funct5), 32'h08);
        chk("model_srai_f5", 32'(m_f5), 32'h08);

        // SLLI with inst[30] set is illegal
        in_valid = 1'b1; in_inst = 32'h40409193;
        step();
        in_valid = 1'b0;
        chk("slli_bad_illegal", 32'(illegal), 32'd1);
        chk("slli_bad_valid", 32'(out_valid), 32'd0);
        step();
        chk("slli_bad_pulse_end", 32'(illegal), 32'd0);

        // Release x3, then ADD x4,x2,x3 stalls on x2 until its writeback
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'd11;
        step();
        wb_valid = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00310233;
        #1 chk("add_stall_ready", 32'(in_ready), 32'd0);
        step();
        chk("add_stall_valid", 32'(out_valid), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'd7;
        #1 chk("add_bypass_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0; wb_valid = 1'b0;
        chk("add_rs1", out_rs1, 32'd7);
        chk("add_rs2", out_rs2, 32'd11);
        chk("add_use_imm", 32'(out_use_imm), 32'd0);
        chk("add_rd", 32'(out_rd), 32'd4);

        // Back-pressure for 3 cycles with XORI x6,x1,-1 waiting
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFFF0C313;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_in_ready", 32'(in_ready), 32'd0);
            step();
            chk("hold_rd", 32'(out_rd), 32'd4);
            chk("hold_rs1", out_rs1, 32'd7);
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        chk("xori_rd", 32'(out_rd), 32'd6);
        chk("xori_imm", out_imm, 32'hFFFFFFFF);
        in_inst = 32'h401082B3;
        step();
        in_valid = 1'b0;
        chk("sub_b2b_valid", 32'(out_valid), 32'd1);
        chk("sub_rd", 32'(out_rd), 32'd5);
        chk("sub_funct5", 32'(out_funct5), 32'h08);
        chk("sub_rs2", out_rs2, 32'd5);

        // WAW: ADDI x5,x0,1 while x5 busy
        in_valid = 1'b1; in_inst = 32'h00100293;
        #1 chk("waw_ready", 32'(in_ready), 32'd0);
        step(2);
        chk("waw_valid", 32'(out_valid), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h99;
        #1 chk("waw_release_ready", 32'(in_ready), 32'd1);
        step();
        wb_valid = 1'b0; in_valid = 1'b0;
        chk("waw_rd", 32'(out_rd), 32'd5);
        chk("waw_imm", out_imm, 32'd1);
        in_valid = 1'b1; in_inst = 32'h0002C393;
        #1 chk("waw_reset_busy", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Reset while a bundle is held and registers are busy
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_rd", 32'(out_rd), 32'd0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h0002C393;
        #1 chk("midrst_busy_clear", 32'(in_ready), 32'd1);
        step();
        chk("midrst_x5", out_rs1, 32'd0);
        in_inst = 32'hFFD08113;
        step();
        in_valid = 1'b0;
        chk("midrst_x1", out_rs1, 32'd0);

        // Unknown opcode and an OP with a bad funct7
        in_valid = 1'b1; in_inst = 32'h00000073;
        step();
        chk("bad_opc_illegal", 32'(illegal), 32'd1);
        in_inst = 32'h40209233;
        step();
        in_valid = 1'b0;
        chk("bad_op_illegal", 32'(illegal), 32'd1);
        chk("bad_op_valid", 32'(out_valid), 32'd0);

        // Writes to x0 are dropped
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'd123;
        step();
        wb_valid = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00500413;
        step();
        in_valid = 1'b0;
        chk("x0_reads_zero", out_rs1, 32'd0);
        chk("x0_imm", out_imm, 32'd5);

        // Same-cycle set and clear of x9 leaves it busy
        in_valid = 1'b1; in_inst = 32'h00100493;
        step();
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h42;
        #1 chk("setclr_ready", 32'(in_ready), 32'd1);
        step();
        wb_valid = 1'b0;
        in_inst = 32'h00048513;
        #1 chk("setwins_stall", 32'(in_ready), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
        step();
        wb_valid = 1'b0; in_valid = 1'b0;
        chk("setwins_bypass", out_rs1, 32'h55);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
